csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
- Initiator side of the machine-mode CSR file. Sequences CSRRW/CSRRS/CSRRC, ECALL and MRET requests from the execute stage.
- Issues reads and dual-port writes to the CSR file, returns the old CSR value for rd, and supplies the trap or return redirect PC.
- Sits between the execute stage (valid/ready on both sides) and the CSR file (raddr, waddr1/2, wdata1/2, ctr[1:0]).

Parameters:
- XLEN, 32, data width of CSRs, rs1 and PC.
- MCAUSE_ECALL, 11, value written to mcause on ECALL (environment call from M-mode).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request from execute.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  operation code: CSRRW=0, CSRRS=1, CSRRC=2, ECALL=3, MRET=4; others are illegal.
- req_addr  in  12  CSR address for CSRRx.
- req_src  in  XLEN  rs1 value or zero-extended immediate.
- req_src_zero  in  1  rs1 index or immediate is 0; suppresses the write for CSRRS/CSRRC.
- req_pc  in  XLEN  PC of the instruction.
- csr_raddr  out  12  CSR file read address.
- csr_rdata  in  XLEN  CSR file combinational read data.
- csr_waddr1, csr_waddr2  out  12 each  CSR write addresses.
- csr_wdata1, csr_wdata2  out  XLEN each  CSR write data.
- csr_ctr  out  2  write control: 00 = none, 10 = port1 only, 11 = both ports.
- resp_valid  out  1  response available.
- resp_ready  in  1  execute accepts the response.
- resp_rdata  out  XLEN  old CSR value (for rd).
- resp_redirect  out  1  PC redirect required.
- resp_pc  out  XLEN  redirect target.
- resp_illegal  out  1  request was illegal.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. One-hot or binary encoding is implementer's choice.
- Reset (rst low, asynchronous):
  - state = IDLE; all latched fields cleared.
  - req_ready = 1; resp_valid = 0; csr_ctr = 00.
  - All address, data and resp_* outputs = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch op/addr/src/src_zero/pc and go to READ.
  - A request is never accepted in any other state; req_ready = 0 there.
- READ (1 cycle): drive csr_raddr, then capture csr_rdata into old_q. Read address by op:
  - CSRRx: req_addr.
  - ECALL: 0x305 (mtvec).
  - MRET: 0x341 (mepc).
  - Illegal op: csr_raddr = 0 and old_q = 0.
- WRITE (1 cycle): csr_ctr is non-zero only in this state, for exactly one clock.
  - CSRRW: ctr = 10; waddr1 = addr; wdata1 = src.
  - CSRRS: wdata1 = old_q | src.
  - CSRRC: wdata1 = old_q & ~src.
  - CSRRS/CSRRC with src_zero = 1: ctr = 00 (read-only access). CSRRW ignores src_zero.
  - ECALL: ctr = 11; waddr1 = 0x341 (mepc), wdata1 = pc; waddr2 = 0x342 (mcause), wdata2 = MCAUSE_ECALL.
  - MRET and illegal ops: ctr = 00.
- RESP:
  - resp_valid = 1. All resp_* outputs are held stable until resp_ready.
  - resp_rdata = old_q for CSRRx, 0 otherwise.
  - resp_redirect = 1 for ECALL (resp_pc = old_q, i.e. mtvec) and MRET (resp_pc = old_q, i.e. mepc); otherwise resp_pc = 0.
  - resp_illegal = 1 for undefined op.
  - On resp_ready, go to IDLE. Minimum latency: accept at cycle N, resp_valid at N+3, next accept at N+4.
- Back-pressure: resp_ready low holds RESP indefinitely. No CSR write is repeated while held.
- Reset mid-operation: the FSM aborts immediately. A write already committed by the CSR file stays committed. No partial write can occur because ctr clears asynchronously.
- Write-data outputs are 0 whenever ctr = 00.

Optional Feature:
- Macro CSR_ACCESS_CHECK_EN.
- Defined: CSRRx to an address other than 0x300/0x305/0x340/0x341/0x342 is illegal. No write occurs (ctr = 00), resp_rdata = 0, resp_illegal = 1.
- Undefined: such addresses pass through unchecked. The read returns whatever the CSR file gives (0), the write is issued normally, and resp_illegal is asserted only for an undefined op.

Decomposition:
- Package csr_pkg holds:
  - op enum (CSR_OP_RW/RS/RC/ECALL/MRET);
  - CSR address constants (MSTATUS, MTVEC, MSCRATCH, MEPC, MCAUSE);
  - csr_ctr encodings (CTR_NONE, CTR_W1, CTR_W12);
  - FSM state typedef.
- One sub-module: csr_wdata_calc, a combinational block mapping op, old value and src to wdata1 and a write enable.

Test Plan:
- CSRRW addr 0x340, src 0xDEADBEEF, old mscratch 0x12345678 -> one WRITE cycle with ctr = 10, waddr1 = 0x340, wdata1 = 0xDEADBEEF; resp_rdata = 0x12345678 at N+3.
- CSRRS addr 0x300, old 0x00000008, src 0x00001800 -> wdata1 = 0x00001808. Same with src_zero = 1 -> ctr stays 00 for all cycles, resp_rdata = 0x00000008.
- ECALL pc 0x80000104, mtvec 0x80000400 -> ctr = 11; mepc written 0x80000104, mcause written 11; resp_redirect = 1, resp_pc = 0x80000400.
- MRET with mepc 0x80000108 -> no write; resp_redirect = 1, resp_pc = 0x80000108. Hold resp_ready low 5 cycles -> outputs stable, req_ready = 0 throughout.
- req_op = 7 -> resp_illegal = 1, ctr = 00. With CSR_ACCESS_CHECK_EN, CSRRW addr 0x7C0 -> resp_illegal = 1 and no write.
- Assert rst low during WRITE of an ECALL -> ctr = 00 and state = IDLE immediately. After release, req_ready = 1 and all resp_* outputs are 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types and constants for the machine-mode CSR access unit: op codes,
// CSR addresses, write-control encodings and FSM states.
package csr_pkg;

    typedef enum logic [2:0] {
        CSR_OP_RW    = 3'd0,
        CSR_OP_RS    = 3'd1,
        CSR_OP_RC    = 3'd2,
        CSR_OP_ECALL = 3'd3,
        CSR_OP_MRET  = 3'd4
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    localparam logic [1:0] CTR_NONE = 2'b00;
    localparam logic [1:0] CTR_W1   = 2'b10;
    localparam logic [1:0] CTR_W12  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic is_csrrx(input logic [2:0] op);
        return (op == CSR_OP_RW) || (op == CSR_OP_RS) || (op == CSR_OP_RC);
    endfunction

    function automatic logic is_defined_op(input logic [2:0] op);
        return op <= CSR_OP_MRET;
    endfunction

    function automatic logic is_known_csr(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) || (addr == CSR_MSCRATCH) ||
               (addr == CSR_MEPC) || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/csr_wdata_calc.sv
// Combinational write-data generator for CSRRW/CSRRS/CSRRC; a set/clear with a
// zero source is a pure read and produces no write enable.
module csr_wdata_calc
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src_i,
    input  logic            src_zero_i,
    output logic [XLEN-1:0] wdata_o,
    output logic            we_o
);

    always_comb begin
        wdata_o = '0;
        we_o    = 1'b0;
        case (op_i)
            CSR_OP_RW: begin
                wdata_o = src_i;
                we_o    = 1'b1;
            end
            CSR_OP_RS: begin
                if (!src_zero_i) begin
                    wdata_o = old_i | src_i;
                    we_o    = 1'b1;
                end
            end
            CSR_OP_RC: begin
                if (!src_zero_i) begin
                    wdata_o = old_i & ~src_i;
                    we_o    = 1'b1;
                end
            end
            default: begin
                wdata_o = '0;
                we_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences CSR read-modify-write, ECALL and MRET against the M-mode CSR file.
// Optional build macro CSR_ACCESS_CHECK_EN rejects CSRRx to unimplemented CSRs.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MCAUSE_ECALL = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_src_zero,
    input  logic [XLEN-1:0] req_pc,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_waddr1,
    output logic [11:0]     csr_waddr2,
    output logic [XLEN-1:0] csr_wdata1,
    output logic [XLEN-1:0] csr_wdata2,
    output logic [1:0]      csr_ctr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_redirect,
    output logic [XLEN-1:0] resp_pc,
    output logic            resp_illegal
);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [11:0]       addr_q;
    logic [XLEN-1:0]   src_q;
    logic              src_zero_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   old_q, old_d;

    logic              access_bad;
    logic              op_illegal;
    logic [XLEN-1:0]   calc_wdata;
    logic              calc_we;

`ifdef CSR_ACCESS_CHECK_EN
    assign access_bad = is_csrrx(op_q) && !is_known_csr(addr_q);
`else
    assign access_bad = 1'b0;
`endif

    assign op_illegal = !is_defined_op(op_q);

    csr_wdata_calc #(
        .XLEN (XLEN)
    ) u_wdata_calc (
        .op_i       (op_q),
        .old_i      (old_q),
        .src_i      (src_q),
        .src_zero_i (src_zero_q),
        .wdata_o    (calc_wdata),
        .we_o       (calc_we)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            pc_q       <= '0;
            old_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                op_q       <= req_op;
                addr_q     <= req_addr;
                src_q      <= req_src;
                src_zero_q <= req_src_zero;
                pc_q       <= req_pc;
            end
            if (state_q == ST_READ) begin
                old_q <= old_d;
            end
        end
    end

    // All CSR-side and response outputs decode from state_q, so an asynchronous
    // reset drops csr_ctr in the same instant and no partial write can slip out.
    always_comb begin
        state_d       = state_q;
        old_d         = '0;
        req_ready     = 1'b0;
        csr_raddr     = '0;
        csr_waddr1    = '0;
        csr_waddr2    = '0;
        csr_wdata1    = '0;
        csr_wdata2    = '0;
        csr_ctr       = CTR_NONE;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_redirect = 1'b0;
        resp_pc       = '0;
        resp_illegal  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
                case (op_q)
                    CSR_OP_RW, CSR_OP_RS, CSR_OP_RC: begin
                        if (!access_bad) begin
                            csr_raddr = addr_q;
                            old_d     = csr_rdata;
                        end
                    end
                    CSR_OP_ECALL: begin
                        csr_raddr = CSR_MTVEC;
                        old_d     = csr_rdata;
                    end
                    CSR_OP_MRET: begin
                        csr_raddr = CSR_MEPC;
                        old_d     = csr_rdata;
                    end
                    default: begin
                        csr_raddr = '0;
                        old_d     = '0;
                    end
                endcase
            end
            ST_WRITE: begin
                state_d = ST_RESP;
                if (op_q == CSR_OP_ECALL) begin
                    csr_ctr    = CTR_W12;
                    csr_waddr1 = CSR_MEPC;
                    csr_wdata1 = pc_q;
                    csr_waddr2 = CSR_MCAUSE;
                    csr_wdata2 = XLEN'(MCAUSE_ECALL);
                end else if (calc_we && !access_bad) begin
                    csr_ctr    = CTR_W1;
                    csr_waddr1 = addr_q;
                    csr_wdata1 = calc_wdata;
                end
            end
            ST_RESP: begin
                resp_valid   = 1'b1;
                resp_illegal = op_illegal || access_bad;
                if (is_csrrx(op_q) && !access_bad) begin
                    resp_rdata = old_q;
                end
                if (op_q == CSR_OP_ECALL || op_q == CSR_OP_MRET) begin
                    resp_redirect = 1'b1;
                    resp_pc       = old_q;
                end
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a behavioural CSR file; honours
// CSR_ACCESS_CHECK_EN for the unimplemented-address case.
module tb_csr_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic [31:0] req_pc;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr1, csr_waddr2;
    logic [31:0] csr_wdata1, csr_wdata2;
    logic [1:0]  csr_ctr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_redirect;
    logic [31:0] resp_pc;
    logic        resp_illegal;

    int n_cmp = 0;
    int n_err = 0;

    csr_access_unit #(
        .XLEN         (32),
        .MCAUSE_ECALL (11)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_src       (req_src),
        .req_src_zero  (req_src_zero),
        .req_pc        (req_pc),
        .csr_raddr     (csr_raddr),
        .csr_rdata     (csr_rdata),
        .csr_waddr1    (csr_waddr1),
        .csr_waddr2    (csr_waddr2),
        .csr_wdata1    (csr_wdata1),
        .csr_wdata2    (csr_wdata2),
        .csr_ctr       (csr_ctr),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_redirect (resp_redirect),
        .resp_pc       (resp_pc),
        .resp_illegal  (resp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CSR file: combinational read, dual-port write on posedge.
    logic [31:0] csr_mem [0:4095];
    logic        mem_clr;
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    assign csr_rdata = csr_mem[csr_raddr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
        end else if (pl_en) begin
            csr_mem[pl_addr] <= pl_data;
        end else begin
            if (csr_ctr[1]) csr_mem[csr_waddr1] <= csr_wdata1;
            if (csr_ctr == 2'b11) csr_mem[csr_waddr2] <= csr_wdata2;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic [31:0] e_rdata, input logic e_redir,
                              input logic [31:0] e_pc, input logic e_ill);
        check_eq({tag, "_valid"},    resp_valid,    1);
        check_eq({tag, "_rdata"},    resp_rdata,    e_rdata);
        check_eq({tag, "_redirect"}, resp_redirect, e_redir);
        check_eq({tag, "_pc"},       resp_pc,       e_pc);
        check_eq({tag, "_illegal"},  resp_illegal,  e_ill);
        check_eq({tag, "_ready_lo"}, req_ready,     0);
        check_eq({tag, "_ctr_lo"},   csr_ctr,       0);
    endtask

    // One full request: accept, watch READ/WRITE, check the single write and the
    // response, optionally stall resp_ready for `hold` cycles, then retire.
    task automatic run_txn(input string name, input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic sz, input logic [31:0] pc,
                           input int hold, input logic [1:0] e_ctr,
                           input logic [11:0] e_wa1, input logic [31:0] e_wd1,
                           input logic [11:0] e_wa2, input logic [31:0] e_wd2,
                           input logic [31:0] e_rdata, input logic e_redir,
                           input logic [31:0] e_pc, input logic e_ill);
        int lat;
        int wr_cnt;
        logic got_resp;
        logic [1:0]  s_ctr;
        logic [11:0] s_wa1, s_wa2;
        logic [31:0] s_wd1, s_wd2;
        lat = 0; wr_cnt = 0; got_resp = 1'b0;
        s_ctr = '0; s_wa1 = '0; s_wa2 = '0; s_wd1 = '0; s_wd2 = '0;

        @(negedge clk);
        check_eq({name, "_ready_idle"}, req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_src = src; req_src_zero = sz; req_pc = pc;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = '0; req_addr = '0;
        req_src = '0; req_src_zero = 1'b0; req_pc = '0;

        for (int c = 0; c < 20 && !got_resp; c++) begin
            @(negedge clk);
            lat++;
            if (csr_ctr != 2'b00) begin
                wr_cnt++;
                s_ctr = csr_ctr; s_wa1 = csr_waddr1; s_wd1 = csr_wdata1;
                s_wa2 = csr_waddr2; s_wd2 = csr_wdata2;
            end else begin
                check_eq({name, "_wquiet"}, {csr_waddr1, csr_waddr2, csr_wdata1, csr_wdata2}, 0);
            end
            if (resp_valid) got_resp = 1'b1;
            else check_eq({name, "_busy_ready"}, req_ready, 0);
        end

        check_eq({name, "_latency"}, lat, 3);
        check_eq({name, "_wr_cycles"}, wr_cnt, (e_ctr != 2'b00) ? 1 : 0);
        check_eq({name, "_ctr"}, s_ctr, e_ctr);
        check_eq({name, "_waddr1"}, s_wa1, e_wa1);
        check_eq({name, "_wdata1"}, s_wd1, e_wd1);
        check_eq({name, "_waddr2"}, s_wa2, e_wa2);
        check_eq({name, "_wdata2"}, s_wd2, e_wd2);
        check_resp({name, "_resp"}, e_rdata, e_redir, e_pc, e_ill);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_resp({name, "_hold"}, e_rdata, e_redir, e_pc, e_ill);
        end

        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_eq({name, "_retire_ready"}, req_ready, 1);
        check_eq({name, "_retire_valid"}, resp_valid, 0);
        $display("txn %s op=%0d addr=0x%03h lat=%0d writes=%0d", name, op, addr, lat, wr_cnt);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
        req_src_zero = 1'b0; req_pc = '0; resp_ready = 1'b0;
        mem_clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        @(negedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_ctr", csr_ctr, 0);
        check_eq("rst_addrs", {csr_raddr, csr_waddr1, csr_waddr2}, 0);
        check_eq("rst_wdata", {csr_wdata1, csr_wdata2}, 0);
        check_eq("rst_resp", {resp_rdata, resp_pc, resp_redirect, resp_illegal}, 0);
        rst = 1'b1;
        $display("txn reset released");

        preload(12'h340, 32'h12345678);
        run_txn("csrrw_mscratch", 3'd0, 12'h340, 32'hDEADBEEF, 1'b0, 32'h0, 0,
                2'b10, 12'h340, 32'hDEADBEEF, 12'h0, 32'h0,
                32'h12345678, 1'b0, 32'h0, 1'b0);
        check_eq("mscratch_after", csr_mem[12'h340], 32'hDEADBEEF);

        preload(12'h300, 32'h00000008);
        run_txn("csrrs_zero", 3'd1, 12'h300, 32'h00001800, 1'b1, 32'h0, 0,
                2'b00, 12'h0, 32'h0, 12'h0, 32'h0,
                32'h00000008, 1'b0, 32'h0, 1'b0);
        run_txn("csrrs_mstatus", 3'd1, 12'h300, 32'h00001800, 1'b0, 32'h0, 0,
                2'b10, 12'h300, 32'h00001808, 12'h0, 32'h0,
                32'h00000008, 1'b0, 32'h0, 1'b0);
        run_txn("csrrc_mstatus", 3'd2, 12'h300, 32'h00000800, 1'b0, 32'h0, 0,
                2'b10, 12'h300, 32'h00001008, 12'h0, 32'h0,
                32'h00001808, 1'b0, 32'h0, 1'b0);

        preload(12'h305, 32'h80000400);
        run_txn("ecall", 3'd3, 12'h0, 32'h0, 1'b0, 32'h80000104, 0,
                2'b11, 12'h341, 32'h80000104, 12'h342, 32'd11,
                32'h0, 1'b1, 32'h80000400, 1'b0);
        check_eq("ecall_mepc", csr_mem[12'h341], 32'h80000104);
        check_eq("ecall_mcause", csr_mem[12'h342], 32'd11);

        preload(12'h341, 32'h80000108);
        run_txn("mret_hold", 3'd4, 12'h0, 32'h0, 1'b0, 32'h0, 5,
                2'b00, 12'h0, 32'h0, 12'h0, 32'h0,
                32'h0, 1'b1, 32'h80000108, 1'b0);

        run_txn("illegal_op", 3'd7, 12'h340, 32'h5, 1'b0, 32'h0, 0,
                2'b00, 12'h0, 32'h0, 12'h0, 32'h0,
                32'h0, 1'b0, 32'h0, 1'b1);

`ifdef CSR_ACCESS_CHECK_EN
        run_txn("csrrw_unknown", 3'd0, 12'h7C0, 32'h55, 1'b0, 32'h0, 0,
                2'b00, 12'h0, 32'h0, 12'h0, 32'h0,
                32'h0, 1'b0, 32'h0, 1'b1);
        check_eq("unknown_untouched", csr_mem[12'h7C0], 32'h0);
`else
        run_txn("csrrw_unknown", 3'd0, 12'h7C0, 32'h55, 1'b0, 32'h0, 0,
                2'b10, 12'h7C0, 32'h55, 12'h0, 32'h0,
                32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("unknown_written", csr_mem[12'h7C0], 32'h55);
`endif

        // Abort an ECALL in its WRITE cycle.
        preload(12'h341, 32'hAAAA0000);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; req_pc = 32'h80000200;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = '0; req_pc = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_ctr_write", csr_ctr, 2'b11);
        rst = 1'b0;
        #1;
        check_eq("abort_ctr", csr_ctr, 0);
        check_eq("abort_ready", req_ready, 1);
        check_eq("abort_waddr", {csr_waddr1, csr_waddr2}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_mepc", csr_mem[12'h341], 32'hAAAA0000);
        check_eq("post_rst_ready", req_ready, 1);
        check_eq("post_rst_resp", {resp_valid, resp_rdata, resp_pc, resp_redirect, resp_illegal}, 0);
        $display("txn ecall_abort mepc=0x%08h", csr_mem[12'h341]);

        run_txn("post_rst_mret", 3'd4, 12'h0, 32'h0, 1'b0, 32'h0, 0,
                2'b00, 12'h0, 32'h0, 12'h0, 32'h0,
                32'h0, 1'b1, 32'hAAAA0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
